// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that feeds NUM_REQ requesters into one FIFO write port.
// Define FIFO_WR_ARB_RETRY_EN to retry an unacknowledged write instead of dropping it.
module fifo_wr_arbiter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [NUM_REQ-1:0]              req_drop,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_wr_ack,
  input  logic                            fifo_overflow,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StWrite, StWaitAck, StRetry} state_e;

  state_e                r_state, w_state_next;
  logic [GW-1:0]         r_grant_id, r_last_grant, w_rr_idx;
  logic                  w_rr_found, w_grant, w_last_upd;
  logic                  r_wr_en;
  logic [FIFO_WIDTH-1:0] r_data;
  logic                  w_unused_overflow;

  // Overflow and "neither flag" are handled identically, so only wr_ack matters.
  assign w_unused_overflow = fifo_overflow;

  // Search starts one past the last served requester.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!w_rr_found && req_valid[(32'(r_last_grant) + i) % NUM_REQ]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = GW'((32'(r_last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign w_grant = (r_state == StIdle) && w_rr_found && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_grant) w_state_next = StWrite;
      StWrite:   w_state_next = StWaitAck;
`ifdef FIFO_WR_ARB_RETRY_EN
      StWaitAck: w_state_next = fifo_wr_ack ? StIdle : StRetry;
      StRetry:   if (!fifo_full) w_state_next = StWrite;
`else
      StWaitAck: w_state_next = StIdle;
      StRetry:   w_state_next = StIdle;
`endif
    endcase
  end

`ifdef FIFO_WR_ARB_RETRY_EN
  assign w_last_upd = (r_state == StWaitAck) && fifo_wr_ack;
`else
  assign w_last_upd = (r_state == StWaitAck);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en      <= 1'b0;
      r_data       <= '0;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
    end else begin
      r_wr_en <= (w_state_next == StWrite);
      if (w_grant) begin
        r_grant_id <= w_rr_idx;
        r_data     <= req_data[32'(w_rr_idx) * FIFO_WIDTH +: FIFO_WIDTH];
      end
      if (w_last_upd) r_last_grant <= r_grant_id;
    end
  end

  always_comb begin
    busy     = (r_state != StIdle);
    req_done = '0;
    req_drop = '0;
    if (r_state == StWaitAck) begin
      if (fifo_wr_ack) begin
        req_done[r_grant_id] = 1'b1;
      end else begin
`ifndef FIFO_WR_ARB_RETRY_EN
        req_drop[r_grant_id] = 1'b1;
`endif
      end
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id     = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed stimulus pushes expected writes and
// done/drop pulses; a negedge monitor pops and compares them against the DUT.
module tb_fifo_wr_arbiter;

  localparam int W = 16;
  localparam int N = 4;
`ifdef FIFO_WR_ARB_RETRY_EN
  localparam logic RetryBusy = 1'b1;
`else
  localparam logic RetryBusy = 1'b0;
`endif

  typedef struct {int cyc; logic [W-1:0] data;} wr_t;
  typedef struct {int cyc; logic is_drop; logic [N-1:0] mask;} ev_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_done, req_drop;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full = 1'b0, fifo_wr_ack = 1'b0, fifo_overflow = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           nack = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int c;
  wr_t wq[$];
  ev_t eq[$];

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_done(req_done), .req_drop(req_drop), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: requesters drop valid after their pulse, FIFO acks the cycle after a write.
  task automatic tick();
    logic [N-1:0] clr;
    logic         wr;
    @(negedge clk);
    clr = req_done | req_drop;
    wr  = fifo_wr_en;
    @(posedge clk);
    #1;
    req_valid     = req_valid & ~clr;
    fifo_wr_ack   = wr & ~nack;
    fifo_overflow = wr & nack;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    wr_t we;
    ev_t ee;
    if (rst_n) begin
      if (fifo_wr_en) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got data %0h at cycle %0d, none expected",
                   fifo_data_in, cyc);
        end else begin
          we = wq.pop_front();
          chk("wr_cycle", cyc, we.cyc);
          chk("wr_data", 32'(fifo_data_in), 32'(we.data));
        end
      end
      if (req_done != '0 || req_drop != '0) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got done %b drop %b at cycle %0d, none expected",
                   req_done, req_drop, cyc);
        end else begin
          ee = eq.pop_front();
          chk("ev_cycle", cyc, ee.cyc);
          chk("ev_done", 32'(req_done), ee.is_drop ? 32'd0 : 32'(ee.mask));
          chk("ev_drop", 32'(req_drop), ee.is_drop ? 32'(ee.mask) : 32'd0);
        end
      end
    end
  end

  initial begin
    req_data = {16'h4004, 16'hA5A5, 16'h2002, 16'h1001};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data", 32'(fifo_data_in), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_drop", 32'(req_drop), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // Single request from requester 2
    req_valid = 4'b0100;
    c = cyc;
    wq.push_back('{c + 1, 16'hA5A5});
    eq.push_back('{c + 2, 1'b0, 4'b0100});
    tick();
    chk("single_grant", 32'(grant_id), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    ticks(5);

    // Fairness from reset: order 0,1,2,3, three cycles each
    do_reset();
    req_valid = 4'b1111;
    c = cyc;
    wq.push_back('{c + 1, 16'h1001});  eq.push_back('{c + 2, 1'b0, 4'b0001});
    wq.push_back('{c + 4, 16'h2002});  eq.push_back('{c + 5, 1'b0, 4'b0010});
    wq.push_back('{c + 7, 16'hA5A5});  eq.push_back('{c + 8, 1'b0, 4'b0100});
    wq.push_back('{c + 10, 16'h4004}); eq.push_back('{c + 11, 1'b0, 4'b1000});
    ticks(12);
    chk("fair_idle_busy", 32'(busy), 32'd0);
    chk("fair_valid_clr", 32'(req_valid), 32'd0);
    ticks(2);

    // Full stall, then release
    fifo_full = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("stall_busy", 32'(busy), 32'd0);
      tick();
    end
    fifo_full = 1'b0;
    c = cyc;
    wq.push_back('{c + 1, 16'h1001});
    eq.push_back('{c + 2, 1'b0, 4'b0001});
    ticks(5);

    // Overflow on requester 1's write, FIFO full for 5 cycles
    nack      = 1'b1;
    req_valid = 4'b0011;
    c = cyc;
    wq.push_back('{c + 1, 16'h2002});
`ifdef FIFO_WR_ARB_RETRY_EN
    wq.push_back('{c + 8, 16'h2002});
    eq.push_back('{c + 9, 1'b0, 4'b0010});
    wq.push_back('{c + 11, 16'h1001});
    eq.push_back('{c + 12, 1'b0, 4'b0001});
`else
    eq.push_back('{c + 2, 1'b1, 4'b0010});
    wq.push_back('{c + 8, 16'h1001});
    eq.push_back('{c + 9, 1'b0, 4'b0001});
`endif
    ticks(2);
    fifo_full = 1'b1;
    tick();
    nack = 1'b0;
    ticks(2);
    chk("ovf_busy", 32'(busy), 32'(RetryBusy));
    chk("ovf_grant", 32'(grant_id), 32'd1);
    chk("ovf_data_hold", 32'(fifo_data_in), 32'h2002);
    ticks(2);
    fifo_full = 1'b0;
    ticks(8);

    // Reset during WRITE: word abandoned, next grant goes to requester 0
    req_valid = 4'b1100;
    tick();
    chk("midwr_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("midwr_data", 32'(fifo_data_in), 32'hA5A5);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pulse", 32'({req_done, req_drop}), 32'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0101;
    c = cyc;
    wq.push_back('{c + 1, 16'h1001});
    eq.push_back('{c + 2, 1'b0, 4'b0001});
    wq.push_back('{c + 4, 16'hA5A5});
    eq.push_back('{c + 5, 1'b0, 4'b0100});
    tick();
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    ticks(8);

    chk("wr_queue_empty", 32'(wq.size()), 32'd0);
    chk("ev_queue_empty", 32'(eq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: data word width, equal to the attached FIFO width.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: bit i set when requester i has a word pending.
REQ-006 SHALL have port req_data, input, NUM_REQ*FIFO_WIDTH bits: requester i word at [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 SHALL have port req_done, output, NUM_REQ bits: one-hot, one-cycle pulse when requester's word is accepted by the FIFO.
REQ-008 SHALL have port req_drop, output, NUM_REQ bits: one-hot, one-cycle pulse when requester's word is discarded on overflow.
REQ-009 SHALL have port fifo_wr_en, output, 1 bit: FIFO write enable, registered.
REQ-010 SHALL have port fifo_data_in, output, FIFO_WIDTH bits: FIFO write data, registered.
REQ-011 SHALL have ports fifo_full, fifo_wr_ack, fifo_overflow, input, 1 bit each: FIFO status.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current/last granted requester.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, WAIT_ACK, RETRY.
REQ-015 IDLE: if any req_valid and fifo_full=0, SHALL grant one requester, capture its req_data into fifo_data_in, set grant_id, go to WRITE; otherwise SHALL stay in IDLE.
REQ-016 Grant selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, first set req_valid wins.
REQ-017 WRITE: fifo_wr_en SHALL be 1 for exactly this one cycle; next state WAIT_ACK.
REQ-018 WAIT_ACK with fifo_wr_ack=1: req_done[grant_id] SHALL be 1 combinationally in this cycle, last_grant<=grant_id, next state IDLE.
REQ-019 WAIT_ACK with fifo_wr_ack=0 (overflow, or neither flag): overflow handling per REQ-027/REQ-028.
REQ-020 Latency: req_valid seen in IDLE at cycle N -> fifo_wr_en in N+1 -> req_done in N+2; sustained throughput one word per 3 cycles.
REQ-021 Requester contract: req_valid held until its req_done/req_drop; requester deasserts req_valid in the cycle after the pulse. Deassertion during a transaction SHALL NOT abort it.
REQ-022 fifo_data_in SHALL stay stable from WRITE through WAIT_ACK and RETRY.
REQ-023 req_done and req_drop SHALL never both be set, and never more than one bit set.

Reset
REQ-024 On rst_n=0, asynchronously: state IDLE, fifo_wr_en=0, fifo_data_in=0, grant_id=0, busy=0, req_done=0, req_drop=0, last_grant=NUM_REQ-1 (requester 0 first).
REQ-025 Reset mid-transaction SHALL abandon the in-flight word with no req_done/req_drop pulse.
REQ-026 First grant after rst_n rises SHALL occur no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-027 With FIFO_WR_ARB_RETRY_EN defined: WAIT_ACK without wr_ack SHALL go to RETRY; RETRY SHALL hold until fifo_full=0, then go to WRITE with the same word and grant_id; req_drop SHALL be constant 0.
REQ-028 Without FIFO_WR_ARB_RETRY_EN: WAIT_ACK without wr_ack SHALL pulse req_drop[grant_id], set last_grant<=grant_id, go to IDLE; RETRY state SHALL be unreachable.

Verification
REQ-029 Single request: req_valid=4'b0100, req_data[2]=16'hA5A5, FIFO empty -> fifo_wr_en one cycle with 16'hA5A5, req_done=4'b0100 two cycles after request.
REQ-030 Fairness: req_valid=4'b1111 held, each requester deasserting after done -> grant order 0,1,2,3, one req_done each, 12 cycles total.
REQ-031 Full stall: fifo_full=1, req_valid=4'b0001 for 10 cycles -> fifo_wr_en stays 0, busy stays 0; fifo_full drops -> write 1 cycle later.
REQ-032 Overflow with FIFO_WR_ARB_RETRY_EN: wr_ack=0, overflow=1 in WAIT_ACK, fifo_full=1 for 5 cycles -> RETRY held, same word rewritten after full drops, then req_done; req_drop never set.
REQ-033 Overflow without macro: same stimulus -> req_drop[grant_id] pulse in WAIT_ACK cycle, next requester granted in following IDLE.
REQ-034 Reset mid-write: rst_n=0 during WRITE -> fifo_wr_en=0 immediately, no req_done/req_drop, next grant to requester 0.
